// File: rtl/crossy_pkg.sv
// Shared types and helpers for the crossy_grid street-crossing game core.
package crossy_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  localparam int unsigned LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10; shift left, feedback into bit 0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic int unsigned mat_idx(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/crossy_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-count debounce, rising-edge event.
module crossy_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic evt_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          evt_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      evt_q   <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q   <= '0;
          level_q <= sync2_q;
          evt_q   <= sync2_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/crossy_grid.sv
// Street-crossing game core: player in bottom row, LFSR-fed obstacle field
// scrolling one row per accepted move, saturating score, blinking game-over.
module crossy_grid
  import crossy_pkg::*;
#(
  parameter int unsigned COLS            = 3,
  parameter int unsigned ROWS            = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          WRAP            = 1'b1,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int unsigned BLINK_CYCLES    = 25000000,
  parameter int unsigned SCORE_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_up,
  output logic [ROWS*COLS-1:0] matrix,
  output logic [SCORE_W-1:0]   score,
  output logic                 game_over
);

  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0]        BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [COLS-1:0]      RIGHT_COL  = COLS'(1);
  localparam logic [COLS-1:0]      LEFT_COL   = COLS'(1) << (COLS - 1);
  localparam logic [COLS-1:0]      CENTER     = COLS'(1) << (COLS / 2);
  localparam logic [ROWS*COLS-1:0] RESET_MAT  = {CENTER, {((ROWS-1)*COLS){1'b0}}};

  logic ev_l, ev_r, ev_u;

  crossy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .reset(reset), .btn_i(btn_left), .evt_o(ev_l)
  );
  crossy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .reset(reset), .btn_i(btn_right), .evt_o(ev_r)
  );
  crossy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .reset(reset), .btn_i(btn_up), .evt_o(ev_u)
  );

  state_e                state_q, state_d;
  logic [COLS-1:0]       pos_q, pos_d;
  logic [COLS-1:0]       obs_q [ROWS-1];
  logic [COLS-1:0]       obs_d [ROWS-1];
  logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic [ROWS*COLS-1:0]  matrix_q, matrix_d;
  logic                  game_over_q;
  logic [COLS-1:0]       next_pos, new_row;
  logic                  move;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    obs_d       = obs_q;
    lfsr_d      = lfsr_q;
    score_d     = score_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    next_pos    = '0;
    move        = 1'b0;
    new_row     = '0;
    matrix_d    = '0;

    for (int unsigned c = 0; c < COLS; c++) begin
      new_row[c] = lfsr_q[8] && (c == (32'(lfsr_q[7:0]) % COLS));
    end

    case (state_q)
      PLAY: begin
        if (ev_l) begin
          move     = 1'b1;
          next_pos = pos_q[COLS-1] ? (WRAP ? RIGHT_COL : '0) : (pos_q << 1);
        end else if (ev_r) begin
          move     = 1'b1;
          next_pos = pos_q[0] ? (WRAP ? LEFT_COL : '0) : (pos_q >> 1);
        end else if (ev_u) begin
          move     = 1'b1;
          next_pos = pos_q;
        end
        if (move && (next_pos != '0)) begin
          // The row about to scroll onto the player decides the collision.
          if ((next_pos & obs_q[ROWS-2]) != '0) begin
            state_d     = OVER;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
          end else begin
            pos_d = next_pos;
            for (int unsigned r = 1; r < ROWS - 1; r++) begin
              obs_d[r] = obs_q[r-1];
            end
            obs_d[0] = new_row;
            lfsr_d   = lfsr_step(lfsr_q);
            if (score_q != '1) begin
              score_d = score_q + SCORE_W'(1);
            end
          end
        end
      end
      OVER: begin
        if (ev_u) begin
          state_d     = PLAY;
          pos_d       = CENTER;
          obs_d       = '{default: '0};
          score_d     = '0;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
      default: state_d = PLAY;
    endcase

    if (state_d == OVER) begin
      matrix_d = blink_on_d ? '1 : '0;
    end else begin
      for (int unsigned r = 0; r < ROWS - 1; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          matrix_d[mat_idx(r, c, COLS)] = obs_d[r][c];
        end
      end
      for (int unsigned c = 0; c < COLS; c++) begin
        matrix_d[mat_idx(ROWS - 1, c, COLS)] = pos_d[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLAY;
      pos_q       <= CENTER;
      obs_q       <= '{default: '0};
      lfsr_q      <= LFSR_SEED;
      score_q     <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      matrix_q    <= RESET_MAT;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      obs_q       <= obs_d;
      lfsr_q      <= lfsr_d;
      score_q     <= score_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      matrix_q    <= matrix_d;
      game_over_q <= (state_d == OVER);
    end
  end

  assign matrix    = matrix_q;
  assign score     = score_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_crossy_grid.sv
// Directed bench for crossy_grid (3x3, debounce 4, blink 8) plus a WRAP=0 instance.
module tb_crossy_grid;

  logic       clk = 1'b0;
  logic       reset;
  logic       bl, br, bu;
  logic       cl, cr, cu;
  logic [8:0] mat, mat_c;
  logic [7:0] sc, sc_c;
  logic       go, go_c;

  int checks = 0;
  int errors = 0;

  logic [2:0]  m_pos, m_obs0, m_obs1;
  logic [15:0] m_lfsr;
  int          m_score;

  always #5 clk = ~clk;

  crossy_grid #(
    .COLS(3), .ROWS(3), .DEBOUNCE_CYCLES(4), .WRAP(1'b1),
    .LFSR_SEED(16'hACE1), .BLINK_CYCLES(8), .SCORE_W(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_left(bl), .btn_right(br), .btn_up(bu),
    .matrix(mat), .score(sc), .game_over(go)
  );

  crossy_grid #(
    .COLS(3), .ROWS(3), .DEBOUNCE_CYCLES(4), .WRAP(1'b0),
    .LFSR_SEED(16'hACE1), .BLINK_CYCLES(8), .SCORE_W(8)
  ) dut_c (
    .clk(clk), .reset(reset), .btn_left(cl), .btn_right(cr), .btn_up(cu),
    .matrix(mat_c), .score(sc_c), .game_over(go_c)
  );

  function automatic logic [15:0] ref_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [2:0] ref_row(input logic [15:0] l);
    logic [2:0] one;
    one = 3'b001;
    return l[8] ? (one << (l[7:0] % 8'd3)) : 3'b000;
  endfunction

  function automatic logic [2:0] ref_next(input logic [2:0] p, input int dir);
    if (dir == 0) return (p == 3'b100) ? 3'b001 : (p << 1);
    if (dir == 1) return (p == 3'b001) ? 3'b100 : (p >> 1);
    return p;
  endfunction

  task automatic press(input logic l, input logic r, input logic u);
    @(negedge clk);
    bl = l; br = r; bu = u;
    repeat (6) @(negedge clk);
    bl = 1'b0; br = 1'b0; bu = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic press_c(input logic l, input logic r, input logic u);
    @(negedge clk);
    cl = l; cr = r; cu = u;
    repeat (6) @(negedge clk);
    cl = 1'b0; cr = 1'b0; cu = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bl = 0; br = 0; bu = 0; cl = 0; cr = 0; cu = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mat !== 9'b010_000_000) begin errors++; $display("FAIL reset_matrix got %b want %b", mat, 9'b010_000_000); end
    checks++; if (sc !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", sc); end
    checks++; if (go !== 1'b0) begin errors++; $display("FAIL reset_game_over got %b want 0", go); end
    checks++; if (mat_c !== 9'b010_000_000) begin errors++; $display("FAIL reset_matrix_c got %b want %b", mat_c, 9'b010_000_000); end
    checks++; if (sc_c !== 8'd0 || go_c !== 1'b0) begin errors++; $display("FAIL reset_c got score %0d go %b want 0 0", sc_c, go_c); end
  endtask

  task automatic test_clamp;
    press_c(1'b1, 1'b0, 1'b0);
    checks++; if (mat_c !== 9'b100_000_000 || sc_c !== 8'd1) begin errors++; $display("FAIL clamp_first_left got %b/%0d want 100000000/1", mat_c, sc_c); end
    press_c(1'b1, 1'b0, 1'b0);
    checks++; if (mat_c !== 9'b100_000_000 || sc_c !== 8'd1) begin errors++; $display("FAIL clamp_edge_left got %b/%0d want 100000000/1", mat_c, sc_c); end
    press_c(1'b0, 1'b0, 1'b1);
    checks++; if (mat_c !== 9'b100_000_001 || sc_c !== 8'd2) begin errors++; $display("FAIL clamp_up1 got %b/%0d want 100000001/2", mat_c, sc_c); end
    press_c(1'b0, 1'b0, 1'b1);
    checks++; if (mat_c !== 9'b100_001_001 || sc_c !== 8'd3) begin errors++; $display("FAIL clamp_up2 got %b/%0d want 100001001/3", mat_c, sc_c); end
    press_c(1'b0, 1'b0, 1'b1);
    checks++; if (mat_c !== 9'b100_001_001 || sc_c !== 8'd4 || go_c !== 1'b0) begin errors++; $display("FAIL clamp_lfsr_held got %b/%0d/%b want 100001001/4/0", mat_c, sc_c, go_c); end
  endtask

  task automatic test_debounce;
    @(negedge clk);
    bu = 1'b1;
    repeat (3) @(negedge clk);
    bu = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (mat !== 9'b010_000_000 || sc !== 8'd0) begin errors++; $display("FAIL short_pulse got %b/%0d want 010000000/0", mat, sc); end
    @(negedge clk);
    bu = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (sc !== 8'd0) begin errors++; $display("FAIL event_early got score %0d want 0", sc); end
    bu = 1'b0;
    @(negedge clk);
    checks++; if (sc !== 8'd1 || mat !== 9'b010_000_000) begin errors++; $display("FAIL event_at_t6 got %b/%0d want 010000000/1", mat, sc); end
    repeat (8) @(negedge clk);
    bu = 1'b1;
    repeat (20) @(negedge clk);
    bu = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (sc !== 8'd2 || mat !== 9'b010_000_001) begin errors++; $display("FAIL long_hold got %b/%0d want 010000001/2", mat, sc); end
    press(1'b0, 1'b0, 1'b1);
    checks++; if (sc !== 8'd3 || mat !== 9'b010_001_001) begin errors++; $display("FAIL third_up got %b/%0d want 010001001/3", mat, sc); end
  endtask

  task automatic test_collision;
    @(negedge clk);
    br = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (go !== 1'b0 || mat !== 9'b010_001_001) begin errors++; $display("FAIL pre_collision got %b/%b want 010001001/0", mat, go); end
    br = 1'b0;
    @(negedge clk);
    checks++; if (go !== 1'b1 || mat !== 9'h1FF || sc !== 8'd3) begin errors++; $display("FAIL collision got %b/%b/%0d want 111111111/1/3", mat, go, sc); end
    repeat (7) @(negedge clk);
    checks++; if (mat !== 9'h1FF) begin errors++; $display("FAIL blink_on_end got %b want 111111111", mat); end
    @(negedge clk);
    checks++; if (mat !== 9'h000) begin errors++; $display("FAIL blink_off got %b want 000000000", mat); end
    repeat (8) @(negedge clk);
    checks++; if (mat !== 9'h1FF) begin errors++; $display("FAIL blink_on_again got %b want 111111111", mat); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checks++; if (go !== 1'b1 || sc !== 8'd3) begin errors++; $display("FAIL over_ignores_lr got %b/%0d want 1/3", go, sc); end
    press(1'b0, 1'b0, 1'b1);
    checks++; if (go !== 1'b0 || mat !== 9'b010_000_000 || sc !== 8'd0) begin errors++; $display("FAIL restart got %b/%b/%0d want 010000000/0/0", mat, go, sc); end
  endtask

  task automatic test_priority;
    press(1'b1, 1'b0, 1'b1);
    checks++; if (mat !== 9'b100_000_001 || sc !== 8'd1 || go !== 1'b0) begin errors++; $display("FAIL priority got %b/%0d want 100000001/1", mat, sc); end
  endtask

  task automatic test_wrap;
    press(1'b1, 1'b0, 1'b0);
    checks++; if (mat !== 9'b001_001_000 || sc !== 8'd2) begin errors++; $display("FAIL wrap_left got %b/%0d want 001001000/2", mat, sc); end
    press(1'b0, 1'b1, 1'b0);
    checks++; if (mat !== 9'b100_000_000 || sc !== 8'd3) begin errors++; $display("FAIL wrap_right got %b/%0d want 100000000/3", mat, sc); end
  endtask

  task automatic test_generation;
    logic [2:0] np;
    int         safe [3];
    int         nsafe;
    int         dir;
    m_pos   = 3'b100;
    m_obs0  = 3'b000;
    m_obs1  = 3'b000;
    m_score = 3;
    m_lfsr  = 16'hACE1;
    for (int i = 0; i < 6; i++) m_lfsr = ref_step(m_lfsr);
    for (int it = 0; it < 260; it++) begin
      nsafe = 0;
      for (int d = 0; d < 3; d++) begin
        np = ref_next(m_pos, d);
        if ((np & m_obs1) == 3'b000) begin
          safe[nsafe] = d;
          nsafe++;
        end
      end
      dir = safe[$urandom_range(nsafe - 1, 0)];
      np = ref_next(m_pos, dir);
      m_pos  = np;
      m_obs1 = m_obs0;
      m_obs0 = ref_row(m_lfsr);
      m_lfsr = ref_step(m_lfsr);
      if (m_score < 255) m_score++;
      press(dir == 0, dir == 1, dir == 2);
      checks++; if (mat !== {m_pos, m_obs1, m_obs0}) begin errors++; $display("FAIL gen_matrix it %0d got %b want %b", it, mat, {m_pos, m_obs1, m_obs0}); end
      checks++; if (sc !== 8'(m_score) || go !== 1'b0) begin errors++; $display("FAIL gen_score it %0d got %0d/%b want %0d/0", it, sc, go, m_score); end
      checks++; if ($countones(mat[5:3]) > 1 || $countones(mat[2:0]) > 1) begin errors++; $display("FAIL gen_popcount it %0d got %b want at most one per row", it, mat[5:0]); end
    end
    checks++; if (sc !== 8'd255) begin errors++; $display("FAIL score_saturate got %0d want 255", sc); end
  endtask

  initial begin
    test_reset;
    test_clamp;
    test_debounce;
    test_collision;
    test_priority;
    test_wrap;
    test_generation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
